// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between two requesters, the shared memory port and mem_port_arbiter.
// The arbiter takes the slave view; the requesters/memory side takes the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m1_req;
  logic          m0_we;
  logic          m1_we;
  logic [AW-1:0] m0_addr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m1_wdata;
  logic          m0_gnt;
  logic          m1_gnt;
  logic          m0_done;
  logic          m1_done;
  logic [DW-1:0] m0_rdata;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in;
  logic          we;
  logic          busy;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, data_in,
    output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata, address, data_out, we, busy
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, data_in,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata, address, data_out, we, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for one synchronous memory port, one transaction in flight, fixed read latency.
// Round-robin by default; defining MEM_ARB_FIXED_PRIO_EN makes m0 win every contended cycle.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_r;
  logic          last_r;
  logic          sel_r;
  logic [3:0]    cnt_r;
  logic          gnt0_r;
  logic          gnt1_r;
  logic          done0_r;
  logic          done1_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;
  logic [AW-1:0] address_r;
  logic [DW-1:0] data_out_r;
  logic          we_r;
  logic          busy_r;

  logic          any_req_s;
  logic          win_s;
  logic          win_we_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_wdata_s;

  // Pick the winner among the current requests
  always_comb begin
    any_req_s = bus.m0_req | bus.m1_req;
    win_s     = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win_s = 1'b0;
`else
      win_s = ~last_r;
`endif
    end else if (bus.m1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Steer the winning master's payload
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    if (win_s) begin
      win_we_s    = bus.m1_we;
      win_addr_s  = bus.m1_addr;
      win_wdata_s = bus.m1_wdata;
    end else begin
      win_we_s    = bus.m0_we;
      win_addr_s  = bus.m0_addr;
      win_wdata_s = bus.m0_wdata;
    end
  end

  // Transaction FSM; every bus-facing output is a register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      last_r     <= 1'b1;
      sel_r      <= 1'b0;
      cnt_r      <= 4'd0;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      rdata0_r   <= '0;
      rdata1_r   <= '0;
      address_r  <= '0;
      data_out_r <= '0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            sel_r      <= win_s;
            last_r     <= win_s;
            address_r  <= win_addr_s;
            data_out_r <= win_wdata_s;
            we_r       <= win_we_s;
            gnt0_r     <= ~win_s;
            gnt1_r     <= win_s;
            busy_r     <= 1'b1;
            state_r    <= ACCESS;
          end else begin
            address_r  <= '0;
            data_out_r <= '0;
            we_r       <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end
        end
        ACCESS: begin
          data_out_r <= '0;
          we_r       <= 1'b0;
          if (we_r) begin
            // Writes complete in the cycle after the access
            address_r <= '0;
            done0_r   <= ~sel_r;
            done1_r   <= sel_r;
            state_r   <= RESP;
          end else begin
            cnt_r   <= 4'(RD_LAT - 1);
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            if (sel_r) begin
              rdata1_r <= bus.data_in;
            end else begin
              rdata0_r <= bus.data_in;
            end
            address_r <= '0;
            done0_r   <= ~sel_r;
            done1_r   <= sel_r;
            state_r   <= RESP;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
            state_r <= WAIT;
          end
        end
        RESP: begin
          address_r <= '0;
          we_r      <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          address_r  <= '0;
          data_out_r <= '0;
          we_r       <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.m0_gnt   = gnt0_r;
  assign bus.m1_gnt   = gnt1_r;
  assign bus.m0_done  = done0_r;
  assign bus.m1_done  = done1_r;
  assign bus.m0_rdata = rdata0_r;
  assign bus.m1_rdata = rdata1_r;
  assign bus.address  = address_r;
  assign bus.data_out = data_out_r;
  assign bus.we       = we_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory of fixed read latency.
// Expected grant order follows MEM_ARB_FIXED_PRIO_EN when it is defined.
module tb_mem_port_arbiter;

  localparam int RD_LAT = 3;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [31:0] mem  [1024];
  logic [31:0] pipe [RD_LAT];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory: synchronous write, read data appears RD_LAT cycles after the address
  always @(posedge clk) begin
    pipe[0] <= mem[bus.address[11:2]];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    if (bus.we) mem[bus.address[11:2]] <= bus.data_out;
  end
  assign bus.data_in = pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] gnt_seq [4];
  int         n_gnt;
  logic       exp_w;

  initial begin
    clk = 1'b0; reset = 1'b1; errors = 0; checks = 0;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.m0_we = 1'b0; bus.m1_we = 1'b0;
    bus.m0_addr = 32'h0; bus.m1_addr = 32'h0; bus.m0_wdata = 32'h0; bus.m1_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    for (int i = 0; i < RD_LAT; i++) pipe[i] <= 32'h0;
    step(); step();
    chk("rst_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
    chk("rst_done", {30'd0, bus.m1_done, bus.m0_done}, 32'd0);
    chk("rst_we_busy", {30'd0, bus.we, bus.busy}, 32'd0);
    chk("rst_addr", bus.address, 32'h0);
    chk("rst_dout", bus.data_out, 32'h0);
    chk("rst_rdata", bus.m0_rdata | bus.m1_rdata, 32'h0);
    reset = 1'b0;
    step();

    // m0 write 0xDEADBEEF to 0x100
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h100; bus.m0_wdata = 32'hDEAD_BEEF;
    step();
    chk("wr_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd1);
    chk("wr_we", 32'(bus.we), 32'd1);
    chk("wr_addr", bus.address, 32'h100);
    chk("wr_dout", bus.data_out, 32'hDEAD_BEEF);
    chk("wr_busy", 32'(bus.busy), 32'd1);
    bus.m0_req = 1'b0;
    step();
    chk("wr_done", {28'd0, bus.m1_done, bus.m0_done, bus.m1_gnt, bus.m0_gnt}, 32'd4);
    chk("wr_we_off", 32'(bus.we), 32'd0);
    step();
    chk("wr_mem", mem[64], 32'hDEAD_BEEF);
    chk("wr_idle", {30'd0, bus.busy, bus.m0_done}, 32'd0);

    // m0 read of 0x100; addr changes after gnt must not matter
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h100;
    step();
    chk("rd_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd1);
    chk("rd_addr1", bus.address, 32'h100);
    chk("rd_we", 32'(bus.we), 32'd0);
    bus.m0_req = 1'b0; bus.m0_addr = 32'h200;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk($sformatf("rd_addr%0d", k), bus.address, 32'h100);
      chk($sformatf("rd_nodone%0d", k), {29'd0, bus.m1_gnt, bus.m1_done, bus.m0_done}, 32'd0);
    end
    step();
    chk("rd_done", {30'd0, bus.m1_done, bus.m0_done}, 32'd1);
    chk("rd_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    chk("rd_m1_rdata", bus.m1_rdata, 32'h0);
    step();
    chk("rd_hold", bus.m0_rdata, 32'hDEAD_BEEF);
    chk("rd_after", {30'd0, bus.busy, bus.m0_done}, 32'd0);

    // m1 request raised while an m0 read of 0x200 is in WAIT
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h200;
    step();
    chk("wq_gnt0", 32'(bus.m0_gnt), 32'd1);
    bus.m0_req = 1'b0;
    step();
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h300; bus.m1_wdata = 32'h1111_1111;
    step();
    chk("wq_nog3", 32'(bus.m1_gnt), 32'd0);
    step();
    chk("wq_nog4", 32'(bus.m1_gnt), 32'd0);
    step();
    chk("wq_done0", {30'd0, bus.m1_gnt, bus.m0_done}, 32'd1);
    chk("wq_rdata0", bus.m0_rdata, 32'hA500_0080);
    step();
    chk("wq_idle", {30'd0, bus.busy, bus.m1_gnt}, 32'd0);
    bus.m1_wdata = 32'h2222_2222;
    step();
    chk("wq_gnt1", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd2);
    chk("wq_addr1", bus.address, 32'h300);
    chk("wq_dout1", bus.data_out, 32'h2222_2222);
    chk("wq_we1", 32'(bus.we), 32'd1);
    bus.m1_req = 1'b0;
    step();
    chk("wq_done1", {30'd0, bus.m1_done, bus.m0_done}, 32'd2);
    step();
    chk("wq_mem", mem[192], 32'h2222_2222);

    // Reset while an m0 read sits in WAIT
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h100;
    step();
    bus.m0_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("mr_state", {29'd0, bus.we, bus.busy, bus.m0_done}, 32'd0);
    chk("mr_addr", bus.address, 32'h0);
    chk("mr_rdata", bus.m0_rdata, 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mr_nodone%0d", k), {30'd0, bus.m0_done, bus.busy}, 32'd0);
    end

    // Both requests held continuously: grant order
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h10; bus.m0_wdata = 32'hAAAA_0000;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h14; bus.m1_wdata = 32'hBBBB_0000;
    n_gnt = 0;
    for (int c = 0; c < 40 && n_gnt < 4; c++) begin
      step();
      chk("rr_excl", {31'd0, (bus.m0_gnt & bus.m1_gnt) | ((bus.m0_gnt | bus.m1_gnt) & (bus.m0_done | bus.m1_done))}, 32'd0);
      if (bus.m0_gnt || bus.m1_gnt) begin
        gnt_seq[n_gnt] = {bus.m1_gnt, bus.m0_gnt};
        n_gnt++;
      end
    end
    chk("rr_count", 32'(n_gnt), 32'd4);
    for (int k = 0; k < n_gnt; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_w = 1'b0;
`else
      exp_w = k[0];
`endif
      chk($sformatf("rr_order%0d", k), {30'd0, gnt_seq[k]}, exp_w ? 32'd2 : 32'd1);
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
